// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Purpose : shared constants and types for the execute-stage branch resolver.
//   DataBusBits        - width of PCs, immediates and register operands
//   STATE_RUN/FLUSH    - encodings of the wrong-path flush FSM
//   upd_bus_t          - predictor update bus payload (PC, target, direction)
//   is_misaligned()    - true when an instruction address is not 4-byte aligned
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

  localparam int DataBusBits = 64;

  // Flush FSM state encodings.
  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_FLUSH = 1'b1;

  // Width of the flush down-counter; holds FLUSH_CYCLES-1 for FLUSH_CYCLES <= 15.
  localparam int FlushCntBits = 4;

  typedef struct packed {
    logic [DataBusBits-1:0] pc;
    logic [DataBusBits-1:0] target;
    logic                   taken;
  } upd_bus_t;

  function automatic logic is_misaligned(input logic [DataBusBits-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_adder.sv
// -----------------------------------------------------------------------------
// adder
// Purpose : plain modulo-2^W adder used for PC+4 and for the target address.
// Ports   :
//   a, b  in  W  operands
//   sum   out W  a + b, carry-out discarded
// -----------------------------------------------------------------------------
module adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/branch_resolve_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Purpose : W-bit event counter that sticks at all-ones instead of wrapping.
// Ports   :
//   clk      in  1  clock
//   reset    in  1  asynchronous active-high reset, clears the count
//   clr_i    in  1  synchronous clear (wins over inc_i)
//   inc_i    in  1  count one event this cycle
//   count_o  out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Purpose : execute-stage resolution of jal / jalr / conditional branches
//           against the fetch-predicted next PC. Drives the predictor update
//           bus, a one-cycle fetch redirect, a multi-cycle wrong-path flush and
//           saturating branch / mispredict counters. All outputs registered.
// Ports   :
//   clk, reset                  clock, asynchronous active-high reset
//   stall                       hold off new resolutions
//   ex_valid, ex_is_jal/jalr/branch, ex_cond   execute-stage instruction info
//   ex_PC, ex_imm, ex_rs1, ex_predictedPC      operands and predicted next PC
//   we, PCUpdate, targetUpdate, takenUpdate    predictor update bus
//   redirect, redirectPC        fetch redirect pulse and correct next PC
//   flush                       kill wrong-path instructions in IF/ID
//   misaligned                  taken target not 4-byte aligned
//   branchCount, mispredictCount performance counters
// -----------------------------------------------------------------------------
import branch_resolve_unit_pkg::*;

module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   ex_valid,
  input  logic                   ex_is_jal,
  input  logic                   ex_is_jalr,
  input  logic                   ex_is_branch,
  input  logic                   ex_cond,
  input  logic [DataBusBits-1:0] ex_PC,
  input  logic [DataBusBits-1:0] ex_imm,
  input  logic [DataBusBits-1:0] ex_rs1,
  input  logic [DataBusBits-1:0] ex_predictedPC,
  output logic                   we,
  output logic [DataBusBits-1:0] PCUpdate,
  output logic [DataBusBits-1:0] targetUpdate,
  output logic                   takenUpdate,
  output logic                   redirect,
  output logic [DataBusBits-1:0] redirectPC,
  output logic                   flush,
  output logic                   misaligned,
  output logic [CNT_W-1:0]       branchCount,
  output logic [CNT_W-1:0]       mispredictCount
);

  localparam logic [FlushCntBits-1:0] FlushLoad = FlushCntBits'(FLUSH_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Target / next-PC datapath
  // ---------------------------------------------------------------------------
  logic [DataBusBits-1:0] pc_plus4;
  logic [DataBusBits-1:0] tgt_opa;
  logic [DataBusBits-1:0] tgt_sum;
  logic [DataBusBits-1:0] target;
  logic [DataBusBits-1:0] actual_next;
  logic                   is_cf;
  logic                   taken;

  adder #(.W(DataBusBits)) u_pc_plus4 (
    .a   (ex_PC),
    .b   (DataBusBits'(4)),
    .sum (pc_plus4)
  );

  // jalr adds to rs1; jal and branches add to the PC.
  assign tgt_opa = ex_is_jalr ? ex_rs1 : ex_PC;

  adder #(.W(DataBusBits)) u_target (
    .a   (tgt_opa),
    .b   (ex_imm),
    .sum (tgt_sum)
  );

  assign target      = ex_is_jalr ? {tgt_sum[DataBusBits-1:1], 1'b0} : tgt_sum;
  assign is_cf       = ex_is_jal | ex_is_jalr | ex_is_branch;
  assign taken       = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_cond);
  assign actual_next = taken ? target : pc_plus4;

  // ---------------------------------------------------------------------------
  // Accept / classify
  // ---------------------------------------------------------------------------
  logic state_q, state_d;
  logic acc;
  logic bad_align;
  logic resolve_ok;
  logic mispredict;

  assign acc        = ex_valid & ~stall & (state_q == STATE_RUN) & is_cf;
  assign bad_align  = taken & is_misaligned(target);
  // A misaligned taken target is an exception, not a resolution.
  assign resolve_ok = acc & ~bad_align;
  assign mispredict = resolve_ok & (actual_next != ex_predictedPC);

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic                   we_q, we_d;
  logic                   redirect_q, redirect_d;
  logic                   misaligned_q, misaligned_d;
  logic [DataBusBits-1:0] redirect_pc_q, redirect_pc_d;
  upd_bus_t               upd_q, upd_d;

  always_comb begin
    we_d          = resolve_ok;
    redirect_d    = mispredict;
    misaligned_d  = acc & bad_align;
    redirect_pc_d = redirect_pc_q;
    upd_d         = upd_q;
    // The update bus is refreshed on every accepted instruction, including a
    // misaligned one, so downstream exception logic sees the faulting target.
    // Consumers still qualify it with we.
    if (acc) begin
      upd_d.pc     = ex_PC;
      upd_d.target = target;
      upd_d.taken  = taken;
    end
    if (mispredict) begin
      redirect_pc_d = actual_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM: flush rises with redirect and stays FLUSH_CYCLES cycles.
  // ---------------------------------------------------------------------------
  logic [FlushCntBits-1:0] flush_cnt_q, flush_cnt_d;
  logic                    flush_q, flush_d;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_d     = flush_q;
    case (state_q)
      STATE_RUN: begin
        if (mispredict) begin
          state_d     = STATE_FLUSH;
          flush_cnt_d = FlushLoad;
          flush_d     = 1'b1;
        end
      end
      STATE_FLUSH: begin
        // Counts regardless of stall: the wrong-path slots must be drained.
        if (flush_cnt_q == '0) begin
          state_d = STATE_RUN;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = STATE_RUN;
        flush_cnt_d = '0;
        flush_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= STATE_RUN;
      flush_cnt_q   <= '0;
      flush_q       <= 1'b0;
      we_q          <= 1'b0;
      redirect_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      redirect_pc_q <= '0;
      upd_q         <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      flush_q       <= flush_d;
      we_q          <= we_d;
      redirect_q    <= redirect_d;
      misaligned_q  <= misaligned_d;
      redirect_pc_q <= redirect_pc_d;
      upd_q         <= upd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (update on the same edge as we / redirect)
  // ---------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (resolve_ok),
    .count_o (branchCount)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (mispredict),
    .count_o (mispredictCount)
  );

  assign we           = we_q;
  assign PCUpdate     = upd_q.pc;
  assign targetUpdate = upd_q.target;
  assign takenUpdate  = upd_q.taken;
  assign redirect     = redirect_q;
  assign redirectPC   = redirect_pc_q;
  assign flush        = flush_q;
  assign misaligned   = misaligned_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Self-checking bench: directed sequences, a table of single-instruction
// vectors and randomized traffic, all compared every cycle against a
// behavioural model. Counters are built 4 bits wide so saturation is reached.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_jal = 1'b0;
  logic        ex_is_jalr = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_cond = 1'b0;
  logic [63:0] ex_PC = '0;
  logic [63:0] ex_imm = '0;
  logic [63:0] ex_rs1 = '0;
  logic [63:0] ex_predictedPC = '0;

  logic          we, takenUpdate, redirect, flush, misaligned;
  logic [63:0]   PCUpdate, targetUpdate, redirectPC;
  logic [CW-1:0] branchCount, mispredictCount;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .ex_valid        (ex_valid),
    .ex_is_jal       (ex_is_jal),
    .ex_is_jalr      (ex_is_jalr),
    .ex_is_branch    (ex_is_branch),
    .ex_cond         (ex_cond),
    .ex_PC           (ex_PC),
    .ex_imm          (ex_imm),
    .ex_rs1          (ex_rs1),
    .ex_predictedPC  (ex_predictedPC),
    .we              (we),
    .PCUpdate        (PCUpdate),
    .targetUpdate    (targetUpdate),
    .takenUpdate     (takenUpdate),
    .redirect        (redirect),
    .redirectPC      (redirectPC),
    .flush           (flush),
    .misaligned      (misaligned),
    .branchCount     (branchCount),
    .mispredictCount (mispredictCount)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  int          m_blocked;   // remaining wrong-path cycles to ignore
  logic        m_we, m_tk, m_redir, m_flush, m_mis;
  logic [63:0] m_pcu, m_tgt, m_rpc;
  int          m_bc, m_mc;

  function automatic logic [63:0] tgt_of(input logic jalr, input logic [63:0] pc,
                                         input logic [63:0] imm, input logic [63:0] rs1);
    logic [63:0] t;
    if (jalr) begin
      t = rs1 + imm;
      t[0] = 1'b0;
    end else begin
      t = pc + imm;
    end
    return t;
  endfunction

  task automatic model_reset();
    m_blocked = 0;
    m_we = 0; m_tk = 0; m_redir = 0; m_flush = 0; m_mis = 0;
    m_pcu = '0; m_tgt = '0; m_rpc = '0;
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_cycle(input logic v, input logic jal, input logic jalr,
                             input logic br, input logic cond, input logic st,
                             input logic [63:0] pc, input logic [63:0] imm,
                             input logic [63:0] rs1, input logic [63:0] pred);
    logic [63:0] t, nxt;
    logic        tk;
    m_we = 0; m_redir = 0; m_mis = 0;
    if (m_blocked > 0) begin
      m_blocked--;
    end else if (v && !st && (jal || jalr || br)) begin
      t   = tgt_of(jalr, pc, imm, rs1);
      tk  = jal | jalr | cond;
      nxt = tk ? t : pc + 64'd4;
      m_pcu = pc; m_tgt = t; m_tk = tk;
      if (tk && (t % 4 != 0)) begin
        m_mis = 1;
      end else begin
        m_we = 1;
        if (m_bc < CMAX) m_bc++;
        if (nxt != pred) begin
          m_redir = 1;
          m_rpc = nxt;
          if (m_mc < CMAX) m_mc++;
          m_blocked = FC;
        end
      end
    end
    m_flush = (m_blocked > 0);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("we", 64'(we), 64'(m_we));
    chk("PCUpdate", PCUpdate, m_pcu);
    chk("targetUpdate", targetUpdate, m_tgt);
    chk("takenUpdate", 64'(takenUpdate), 64'(m_tk));
    chk("redirect", 64'(redirect), 64'(m_redir));
    chk("redirectPC", redirectPC, m_rpc);
    chk("flush", 64'(flush), 64'(m_flush));
    chk("misaligned", 64'(misaligned), 64'(m_mis));
    chk("branchCount", 64'(branchCount), 64'(m_bc));
    chk("mispredictCount", 64'(mispredictCount), 64'(m_mc));
  endtask

  task automatic step(input logic v, input logic jal, input logic jalr,
                      input logic br, input logic cond, input logic st,
                      input logic [63:0] pc, input logic [63:0] imm,
                      input logic [63:0] rs1, input logic [63:0] pred);
    ex_valid = v; ex_is_jal = jal; ex_is_jalr = jalr; ex_is_branch = br;
    ex_cond = cond; stall = st; ex_PC = pc; ex_imm = imm; ex_rs1 = rs1;
    ex_predictedPC = pred;
    @(posedge clk);
    model_cycle(v, jal, jalr, br, cond, st, pc, imm, rs1, pred);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        v, jal, jalr, br, cond, st;
    logic [63:0] pc, imm, rs1, pred;
    logic        e_we, e_redir, e_mis, chk_upd, e_tk;
    logic [63:0] e_tgt, e_rpc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic jal, input logic jalr, input logic br,
                     input logic cond, input logic st, input logic [63:0] pc,
                     input logic [63:0] imm, input logic [63:0] rs1, input logic [63:0] pred,
                     input logic e_we, input logic e_redir, input logic e_mis,
                     input logic chk_upd, input logic e_tk, input logic [63:0] e_tgt,
                     input logic [63:0] e_rpc);
    vec_t x;
    x.v = v; x.jal = jal; x.jalr = jalr; x.br = br; x.cond = cond; x.st = st;
    x.pc = pc; x.imm = imm; x.rs1 = rs1; x.pred = pred;
    x.e_we = e_we; x.e_redir = e_redir; x.e_mis = e_mis; x.chk_upd = chk_upd;
    x.e_tk = e_tk; x.e_tgt = e_tgt; x.e_rpc = e_rpc;
    tbl.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //         v jal jalr br cond st  pc        imm       rs1       pred      we rd mis cu tk tgt       rpc
    add(1, 0, 0, 1, 1, 0, 64'h100, 64'h20, 64'h0, 64'h120, 1, 0, 0, 1, 1, 64'h120, 64'h0);
    add(1, 0, 0, 1, 0, 0, 64'h200, 64'h40, 64'h0, 64'h240, 1, 1, 0, 1, 0, 64'h240, 64'h204);
    add(1, 0, 1, 0, 0, 0, 64'h100, 64'h0, 64'h1003, 64'h104, 0, 0, 1, 1, 1, 64'h1002, 64'h0);
    add(1, 1, 0, 0, 0, 0, 64'h300, 64'h10, 64'h0, 64'h310, 1, 0, 0, 1, 1, 64'h310, 64'h0);
    add(1, 1, 0, 0, 0, 0, 64'h300, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h304, 1, 1, 0, 1, 1, 64'h2F8, 64'h2F8);
    add(1, 0, 0, 1, 0, 0, 64'h400, 64'h80, 64'h0, 64'h404, 1, 0, 0, 1, 0, 64'h480, 64'h0);
    add(1, 0, 0, 1, 1, 0, 64'h500, 64'h6, 64'h0, 64'h506, 0, 0, 1, 1, 1, 64'h506, 64'h0);
    add(1, 0, 0, 1, 0, 0, 64'h500, 64'h6, 64'h0, 64'h504, 1, 0, 0, 1, 0, 64'h506, 64'h0);
    add(1, 0, 1, 0, 0, 0, 64'h600, 64'h3, 64'h2001, 64'h2004, 1, 0, 0, 1, 1, 64'h2004, 64'h0);
    add(1, 0, 0, 0, 1, 0, 64'h700, 64'h4, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    add(1, 1, 0, 0, 0, 1, 64'h800, 64'h10, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    add(1, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 64'h10, 1, 0, 0, 1, 1, 64'h10, 64'h0);
    add(1, 0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0, 64'h0, 1, 0, 0, 1, 0, 64'h4, 64'h0);
    add(1, 0, 1, 0, 0, 0, 64'h900, 64'h7, 64'h3000, 64'h904, 0, 0, 1, 1, 1, 64'h3006, 64'h0);
    add(1, 0, 0, 1, 1, 0, 64'hA00, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'hA04, 1, 1, 0, 1, 1, 64'h9F0, 64'h9F0);

    // ---- reset state ----
    model_reset();
    #12;
    check_model();
    chk("reset_flush", 64'(flush), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---- taken branch, correctly predicted ----
    step(1, 0, 0, 1, 1, 0, 64'h100, 64'h20, 64'h0, 64'h120);
    chk("first_branchCount", 64'(branchCount), 64'd1);

    // ---- mispredict, then two wrong-path branches ignored, third accepted ----
    step(1, 0, 0, 1, 0, 0, 64'h200, 64'h40, 64'h0, 64'h240);
    chk("mp_redirectPC", redirectPC, 64'h204);
    chk("mp_flush", 64'(flush), 64'h1);
    chk("mp_count", 64'(mispredictCount), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1, 1, 0, 64'h300, 64'h8, 64'h0, 64'h308);
      chk("wrongpath_we", 64'(we), 64'h0);
      chk("wrongpath_bc", 64'(branchCount), 64'd2);
      chk("wrongpath_flush", 64'(flush), (i == 0) ? 64'h1 : 64'h0);
    end
    step(1, 0, 0, 1, 1, 0, 64'h300, 64'h8, 64'h0, 64'h308);
    chk("third_we", 64'(we), 64'h1);
    chk("third_bc", 64'(branchCount), 64'd3);

    // ---- stall holds off a jal; release resolves it ----
    step(1, 1, 0, 0, 0, 1, 64'h400, 64'h40, 64'h0, 64'h440);
    chk("stall_we", 64'(we), 64'h0);
    step(1, 1, 0, 0, 0, 0, 64'h400, 64'h40, 64'h0, 64'h440);
    chk("unstall_we", 64'(we), 64'h1);
    chk("unstall_tgt", targetUpdate, 64'h440);

    // ---- reset in the first flush cycle ----
    step(1, 1, 0, 0, 0, 0, 64'h500, 64'h100, 64'h0, 64'h504);
    chk("prereset_flush", 64'(flush), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_flush", 64'(flush), 64'h0);
    chk("async_redirect", 64'(redirect), 64'h0);
    chk("async_bc", 64'(branchCount), 64'h0);
    chk("async_mc", 64'(mispredictCount), 64'h0);
    model_reset();
    check_model();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 1, 1, 0, 64'h600, 64'h10, 64'h0, 64'h610);
    chk("postreset_we", 64'(we), 64'h1);
    chk("postreset_bc", 64'(branchCount), 64'd1);
    idle(1);

    // ---- table vectors, each from RUN ----
    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].jal, tbl[k].jalr, tbl[k].br, tbl[k].cond, tbl[k].st,
           tbl[k].pc, tbl[k].imm, tbl[k].rs1, tbl[k].pred);
      chk($sformatf("tbl%0d_we", k), 64'(we), 64'(tbl[k].e_we));
      chk($sformatf("tbl%0d_redirect", k), 64'(redirect), 64'(tbl[k].e_redir));
      chk($sformatf("tbl%0d_misaligned", k), 64'(misaligned), 64'(tbl[k].e_mis));
      if (tbl[k].chk_upd) begin
        chk($sformatf("tbl%0d_taken", k), 64'(takenUpdate), 64'(tbl[k].e_tk));
        chk($sformatf("tbl%0d_target", k), targetUpdate, tbl[k].e_tgt);
        chk($sformatf("tbl%0d_pc", k), PCUpdate, tbl[k].pc);
      end
      if (tbl[k].e_redir) begin
        chk($sformatf("tbl%0d_redirectPC", k), redirectPC, tbl[k].e_rpc);
      end
      idle(3);
    end

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      logic        v, jal, jalr, br, cond, st;
      logic [63:0] pc, imm, rs1, pred, t, nxt;
      int unsigned kind, pk;
      logic [11:0] r;
      kind = $urandom_range(0, 4);
      v    = ($urandom_range(0, 9) != 0);
      jal  = (kind == 0);
      jalr = (kind == 1);
      br   = (kind == 2) || (kind == 3);
      cond = $urandom_range(0, 1) != 0;
      st   = ($urandom_range(0, 4) == 0);
      pc   = {32'h0, $urandom} & ~64'd3;
      r    = 12'($urandom);
      r[0] = 1'b0;
      imm  = {{52{r[11]}}, r};
      rs1  = {32'h0, $urandom};
      t    = tgt_of(jalr, pc, imm, rs1);
      nxt  = (jal | jalr | (br & cond)) ? t : pc + 64'd4;
      pk   = $urandom_range(0, 3);
      pred = (pk < 2) ? nxt : ((pk == 2) ? pc + 64'd4 : ({32'h0, $urandom} & ~64'd3));
      step(v, jal, jalr, br, cond, st, pc, imm, rs1, pred);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
